// File: rtl/ptp_punch.sv
// PC8E high-speed punch: decodes punch IOTs, buffers one byte, and sends 8N1 frames on tx.
// Flag is set at stop-bit completion; a byte queued in the holding buffer follows with no idle gap.
module ptp_punch #(
    parameter int         CLOCK_FREQ = 100000000,
    parameter int         BAUD       = 115200,
    parameter logic [5:0] DEV        = 6'o02,
    parameter logic [4:0] IOT_STATE  = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [4:0]  state,
    input  logic [0:11] instruction,
    input  logic [0:11] ac,
    input  logic        rpe,
    output logic        tx,
    output logic        interrupt,
    output logic        skip
);
    localparam int DIV   = CLOCK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       fsm;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shifter;
    logic [7:0]       hold;
    logic             hold_full;
    logic             flag;
    logic             ie;
    logic             iot_d;
    logic             skip_flag;

    logic       iot;
    logic       first;
    logic       do_pce;
    logic       do_pcf;
    logic       do_ppc;
    logic       bit_done;
    logic       frame_end;
    logic       start_frame;
    logic [7:0] ac_byte;
    logic       unused_ac;

    assign iot       = (state == IOT_STATE) && (instruction[0:2] == 3'b110) && (instruction[3:8] == DEV);
    assign first     = iot & ~iot_d;
    assign do_pce    = first && (instruction[9:11] == 3'b000);
    assign do_pcf    = first & instruction[10];
    assign do_ppc    = first & instruction[9];
    assign ac_byte   = ac[4:11];
    assign unused_ac = ^ac[0:3];

    assign bit_done    = (baud_cnt == LAST);
    assign frame_end   = (fsm == S_STOP) && bit_done;
    // A new frame starts from idle or straight out of a finishing stop bit.
    assign start_frame = ((fsm == S_IDLE) || frame_end) && (hold_full || do_ppc);

    // Skip reports the flag as it was when the IOT began, even if the IOT clears it.
    assign skip      = iot & instruction[11] & (first ? flag : skip_flag);
    assign interrupt = flag & ie;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            fsm       <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shifter   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            flag      <= 1'b0;
            ie        <= 1'b1;
            iot_d     <= 1'b0;
            skip_flag <= 1'b0;
            tx        <= 1'b1;
        end else begin
            iot_d <= iot;
            if (first)
                skip_flag <= flag;

            if (frame_end)
                flag <= 1'b1;
            else if (do_pcf)
                flag <= 1'b0;

            if (rpe)
                ie <= 1'b1;
            else if (do_pce)
                ie <= 1'b0;

            // With an empty holding buffer and a frame starting, the new byte bypasses holding.
            if (do_ppc && !(start_frame && !hold_full)) begin
                hold      <= ac_byte;
                hold_full <= 1'b1;
            end else if (start_frame) begin
                hold_full <= 1'b0;
            end

            if (start_frame) begin
                fsm      <= S_START;
                shifter  <= hold_full ? hold : ac_byte;
                baud_cnt <= '0;
                tx       <= 1'b0;
            end else begin
                case (fsm)
                    S_IDLE: tx <= 1'b1;
                    S_START: begin
                        if (bit_done) begin
                            fsm      <= S_DATA;
                            baud_cnt <= '0;
                            bit_cnt  <= '0;
                            tx       <= shifter[0];
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (bit_done) begin
                            baud_cnt <= '0;
                            if (bit_cnt == 3'd7) begin
                                fsm <= S_STOP;
                                tx  <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                shifter <= shifter >> 1;
                                tx      <= shifter[1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (bit_done) begin
                            fsm <= S_IDLE;
                            tx  <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    default: fsm <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ptp_punch.sv
// Bench for ptp_punch: directed vectors and sequences plus randomized IOT traffic
// checked every cycle against a frame-schedule reference model.
module tb_ptp_punch;
    localparam int         DIV      = 16;
    localparam logic [4:0] IOT_ST   = 5'd2;
    localparam logic [4:0] OTHER_ST = 5'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [4:0]  state;
    logic [0:11] instruction;
    logic [0:11] ac;
    logic        rpe;
    logic        tx;
    logic        interrupt;
    logic        skip;

    ptp_punch #(
        .CLOCK_FREQ(1600),
        .BAUD      (100),
        .DEV       (6'o02),
        .IOT_STATE (IOT_ST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .state      (state),
        .instruction(instruction),
        .ac         (ac),
        .rpe        (rpe),
        .tx         (tx),
        .interrupt  (interrupt),
        .skip       (skip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  st;
        logic [11:0] ins;
        logic        exp_skip;
        logic        exp_int;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: frames are described by their start cycle and byte.
    int         mt;
    bit         m_busy;
    int         m_s;
    logic [7:0] m_cur;
    bit         m_pend_vld;
    logic [7:0] m_pend;
    bit         m_flag;
    bit         m_ie;
    bit         m_iot_prev;
    bit         m_skip_flag;
    bit         m_tx;

    logic s_tx;
    logic s_int;
    logic s_skip;
    int   s_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, s_cyc, act, exp);
        end
    endtask

    function automatic bit wave(input int o, input logic [7:0] b);
        if (o < DIV) return 1'b0;
        if (o < 9 * DIV) return b[o / DIV - 1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_busy      = 1'b0;
        m_pend_vld  = 1'b0;
        m_flag      = 1'b0;
        m_ie        = 1'b1;
        m_iot_prev  = 1'b0;
        m_skip_flag = 1'b0;
        m_tx        = 1'b1;
    endtask

    task automatic step(input logic [4:0] st, input logic [11:0] ins, input logic [11:0] acv,
                        input bit rst_n, input bit clr, input bit rp);
        bit          is_iot;
        bit          first;
        bit          exp_skip;
        bit          end_set;
        logic [0:11] ib;
        state       = st;
        instruction = ins;
        ac          = acv;
        reset       = rst_n;
        clear       = clr;
        rpe         = rp;
        ib       = ins;
        is_iot   = (st == IOT_ST) && (ib[0:2] == 3'b110) && (ib[3:8] == 6'o02);
        first    = is_iot && !m_iot_prev;
        exp_skip = is_iot && ib[11] && (first ? m_flag : m_skip_flag);
        @(negedge clk);
        s_cyc  = mt;
        s_tx   = tx;
        s_int  = interrupt;
        s_skip = skip;
        chk("model_tx", tx, m_tx);
        chk("model_interrupt", interrupt, m_flag & m_ie);
        chk("model_skip", skip, exp_skip);
        if (!rst_n || clr) begin
            model_reset();
        end else begin
            if (first) m_skip_flag = m_flag;
            m_iot_prev = is_iot;
            end_set = m_busy && (mt + 1 == m_s + 10 * DIV);
            if (end_set) m_busy = 1'b0;
            if (first && ib[10]) m_flag = 1'b0;
            if (end_set) m_flag = 1'b1;
            if (first && ib[9:11] == 3'b000) m_ie = 1'b0;
            if (rp) m_ie = 1'b1;
            if (!m_busy && m_pend_vld) begin
                m_busy     = 1'b1;
                m_s        = mt + 1;
                m_cur      = m_pend;
                m_pend_vld = 1'b0;
            end
            if (first && ib[9]) begin
                if (!m_busy) begin
                    m_busy = 1'b1;
                    m_s    = mt + 1;
                    m_cur  = acv[7:0];
                end else begin
                    m_pend     = acv[7:0];
                    m_pend_vld = 1'b1;
                end
            end
        end
        m_tx = m_busy ? wave(mt + 1 - m_s, m_cur) : 1'b1;
        mt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(OTHER_ST, 12'o0000, 12'o0000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic iot(input logic [11:0] ins, input logic [11:0] acv);
        step(IOT_ST, ins, acv, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic run_to(input int c);
        while (mt <= c) idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        bit          saw0;
        logic [7:0]  eb;
        logic [11:0] ops [8];
        vec_t        tbl [6];

        tbl[0] = '{IOT_ST,   12'o6021, 1'b1, 1'b1};
        tbl[1] = '{OTHER_ST, 12'o6021, 1'b0, 1'b1};
        tbl[2] = '{IOT_ST,   12'o6031, 1'b0, 1'b1};
        tbl[3] = '{IOT_ST,   12'o2021, 1'b0, 1'b1};
        tbl[4] = '{IOT_ST,   12'o6121, 1'b0, 1'b1};
        tbl[5] = '{IOT_ST,   12'o6001, 1'b0, 1'b1};
        ops = '{12'o6024, 12'o6026, 12'o6022, 12'o6021, 12'o6023, 12'o6020, 12'o6027, 12'o6025};

        state = OTHER_ST; instruction = '0; ac = '0; reset = 1'b0; clear = 1'b0; rpe = 1'b0;
        mt = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        idle();
        chk("reset_tx", s_tx, 1);
        chk("reset_interrupt", s_int, 0);
        chk("reset_skip", s_skip, 0);

        // PLS 6026 of 0301 -> 0xC1
        iot(12'o6026, 12'o0301);
        n = s_cyc;
        run_to(n + 1);
        chk("pls_start_bit", s_tx, 0);
        eb = 8'hC1;
        for (int k = 0; k < 8; k++) begin
            run_to(n + 1 + (k + 1) * DIV + DIV / 2);
            chk("pls_data_bit", s_tx, eb[k]);
        end
        run_to(n + 9 * DIV + 8);
        chk("pls_stop_bit", s_tx, 1);
        run_to(n + 160);
        chk("pls_flag_early", s_int, 0);
        run_to(n + 161);
        chk("pls_flag_set", s_int, 1);

        foreach (tbl[i]) begin
            step(tbl[i].st, tbl[i].ins, 12'o0000, 1'b1, 1'b0, 1'b0);
            chk("tbl_skip", s_skip, tbl[i].exp_skip);
            idle();
            chk("tbl_interrupt", s_int, tbl[i].exp_int);
        end

        // skip held for a multi-cycle IOT, then skip-and-clear, then skip with flag clear
        repeat (3) begin
            iot(12'o6021, 12'o0000);
            chk("psf_held_skip", s_skip, 1);
        end
        idle();
        iot(12'o6023, 12'o0000);
        chk("psf_pcf_skip", s_skip, 1);
        idle();
        chk("psf_pcf_flag_cleared", s_int, 0);
        iot(12'o6021, 12'o0000);
        chk("psf_flag0_skip", s_skip, 0);
        idle();

        // back-to-back PPC, overwrite, and PPC on the unload cycle
        iot(12'o6024, 12'h055);
        n = s_cyc;
        run_to(n + 19);
        iot(12'o6024, 12'h0AA);
        run_to(n + 39);
        iot(12'o6024, 12'h0F0);
        run_to(n + 159);
        iot(12'o6024, 12'h03C);
        chk("b2b_last_stop_cycle", s_tx, 1);
        run_to(n + 161);
        chk("b2b_second_start", s_tx, 0);
        chk("b2b_first_flag", s_int, 1);
        eb = 8'hF0;
        for (int k = 0; k < 8; k++) begin
            run_to(n + 161 + (k + 1) * DIV + DIV / 2);
            chk("b2b_overwrite_bit", s_tx, eb[k]);
        end
        run_to(n + 320);
        chk("b2b_second_stop", s_tx, 1);
        run_to(n + 321);
        chk("b2b_third_start", s_tx, 0);
        run_to(n + 500);

        // PCE drops interrupt but not flag; rpe restores it
        iot(12'o6020, 12'o0000);
        idle();
        chk("pce_interrupt", s_int, 0);
        iot(12'o6021, 12'o0000);
        chk("pce_flag_kept", s_skip, 1);
        idle();
        step(OTHER_ST, 12'o0000, 12'o0000, 1'b1, 1'b0, 1'b1);
        idle();
        chk("rpe_interrupt", s_int, 1);

        // reset mid-frame
        iot(12'o6022, 12'o0000);
        idle();
        iot(12'o6024, 12'h0A5);
        n = s_cyc;
        run_to(n + 49);
        step(OTHER_ST, 12'o0000, 12'o0000, 1'b0, 1'b0, 1'b0);
        idle();
        chk("reset_mid_tx", s_tx, 1);
        chk("reset_mid_interrupt", s_int, 0);
        saw0 = 1'b0;
        repeat (200) begin
            idle();
            if (s_tx == 1'b0) saw0 = 1'b1;
        end
        chk("reset_mid_no_bits", saw0, 0);
        iot(12'o6024, 12'h011);
        n = s_cyc;
        run_to(n + 161);
        chk("reset_ie_set", s_int, 1);

        // clear mid-frame
        iot(12'o6026, 12'h000);
        n = s_cyc;
        run_to(n + 29);
        step(OTHER_ST, 12'o0000, 12'o0000, 1'b1, 1'b1, 1'b0);
        idle();
        chk("clear_mid_tx", s_tx, 1);
        chk("clear_mid_interrupt", s_int, 0);

        // PCF in the stop-completion cycle: set wins
        iot(12'o6024, 12'h012);
        n = s_cyc;
        run_to(n + 159);
        iot(12'o6022, 12'o0000);
        idle();
        chk("pcf_vs_set", s_int, 1);

        // wrong device code
        iot(12'o6034, 12'h0FF);
        chk("wrong_dev_skip", s_skip, 0);
        saw0 = 1'b0;
        repeat (40) begin
            idle();
            if (s_tx == 1'b0) saw0 = 1'b1;
        end
        chk("wrong_dev_tx", saw0, 0);
        chk("wrong_dev_flag", s_int, 1);

        // randomized traffic against the model
        for (int i = 0; i < 5000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r < 10) begin
                logic [11:0] op;
                logic [11:0] av;
                op = ops[$urandom_range(0, 7)];
                av = 12'($urandom);
                repeat ($urandom_range(1, 3)) iot(op, av);
            end else if (r < 12) begin
                step(OTHER_ST, 12'o0000, 12'o0000, 1'b1, 1'b0, 1'b1);
            end else if (r == 12) begin
                step(OTHER_ST, 12'o0000, 12'o0000, 1'b1, 1'b1, 1'b0);
            end else if (r == 13) begin
                step(OTHER_ST, 12'o0000, 12'o0000, 1'b0, 1'b0, 1'b0);
            end else begin
                idle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ptp_punch.md
# ptp_punch

High-speed paper-tape punch (PC8E punch half, device 02) for the PDP8e core. It decodes punch IOTs from the instruction bus during the IOT execute state and latches AC[4:11] into a one-deep holding buffer. It shifts bytes out as 8N1 serial frames on a dedicated TX pin, raising the punch flag, interrupt and skip in the same style as the console serial block. It sits beside the console serial block, shares the ac/state/instruction buses, and its `interrupt` and `skip` are ORed into the CPU interrupt request and IOT skip.

## Interface
Parameters:
- CLOCK_FREQ, 100000000: clk frequency in Hz.
- BAUD, 115200: serial bit rate. DIV = CLOCK_FREQ/BAUD, truncated; DIV ≥ 2.
- DEV, 6'o02: IOT device code matched against instruction[3:8].
- IOT_STATE, 5'd0: `state` encoding of the IOT execute state. Overridden at instantiation with the codebase's state parameter.

Ports:
- clk, in, 1: system clock (100 MHz domain).
- reset, in, 1: **synchronous, active-low** reset.
- clear, in, 1: debounced front-panel CLEAR pulse, active high. Has the same effect as reset.
- state, in, 5: CPU major state.
- instruction, in, 12 [0:11]: current instruction (MB).
- ac, in, 12 [0:11]: registered accumulator. Bits [4:11] are the punch data.
- rpe, in, 1: one-cycle pulse from the reader's RPE IOT (6010). Sets the shared interrupt enable.
- tx, out, 1: serial output, idle high.
- interrupt, out, 1: flag AND interrupt-enable.
- skip, out, 1: IOT skip request.

## Operation
IOT detect:
- iot = (state == IOT_STATE) && instruction[0:2] == 3'b110 && instruction[3:8] == DEV.
- All actions fire once, on the first clk cycle of iot (rising edge of iot). skip is held for the whole state.

Microcoded bits, combined in one IOT and applied in the order skip, clear, load:
- 6020 (bits 9-11 = 0), PCE: clear interrupt enable (ie).
- bit 11, PSF: skip = flag, using the pre-IOT flag value.
- bit 10, PCF: clear flag.
- bit 9, PPC: load ac[4:11] into the holding buffer and set hold_full. 6026 (PLS) = clear flag + load.

Transmitter FSM:
- States: IDLE, START, DATA, STOP. bit_cnt is 0-7; baud counter runs 0..DIV-1.
- IDLE with hold_full: move holding buffer into shifter, clear hold_full, go to START, tx = 0.
- Each state lasts DIV cycles.
- DATA sends shifter bit 0 first (LSB first), 8 bits.
- STOP drives tx = 1 for DIV cycles. At the end of STOP the flag is set, then the FSM goes to IDLE, or directly to START if hold_full.

Flags and enables:
- ie is set by reset, clear, or rpe; it is cleared by 6020.
- interrupt = flag & ie, combinational from registers.

Buffer rules:
- PPC while the shifter is busy and holding is empty: the byte is queued.
- PPC while holding is full: holding is overwritten (last write wins); there is no error indication.

## Timing
Reset and clear values:
- reset low or clear high → next cycle: tx = 1, FSM = IDLE, hold_full = 0, flag = 0, ie = 1, interrupt = 0, skip = 0.
- This takes effect mid-frame too: the frame is truncated and no flag is set.

Frame timing:
- PPC on first iot cycle N, FSM IDLE: tx falls at N+1.
- Data bit k occupies cycles N+1+(k+1)·DIV through N+(k+2)·DIV.
- Stop bit ends, and flag = 1, at cycle N+1+10·DIV.
- A queued byte starts its start bit at the cycle after stop ends, with no idle gap.

Simultaneous events:
- Flag-set at end of stop in the same cycle as a PCF: set wins.
- PPC and FSM-unload of holding in the same cycle: the new byte lands in holding, and hold_full remains 1.

Outputs:
- skip = iot & instruction[11] & flag_at_iot_entry. It is combinational and is 0 outside iot.
- No flag change occurs except at stop completion, PCF, reset, and clear.

## Test plan
All scenarios use CLOCK_FREQ=1600, BAUD=100, so DIV = 16.
- Reset release then PLS 6026 with ac=12'o0301: tx low at N+1. Then bits 1,0,0,0,0,0,1,1 (0xC1, LSB first), 16 cycles each. Then stop high. Flag = 1 at N+161, and interrupt = 1.
- PSF 6021 with flag=1 → skip=1 for the whole iot. PSF with flag=0 → skip=0. 6023 with flag=1 → skip=1 and flag = 0 the next cycle.
- Back-to-back PPC 6024 of 0x55 then 0xAA during the first frame: the second frame's start bit begins the cycle after the first stop bit ends. A third PPC while holding is full replaces 0xAA.
- 6020 with flag=1 → interrupt drops to 0 while flag stays 1. An rpe pulse → interrupt = 1 again.
- reset low at cycle N+50 of a frame → tx = 1 at N+51. Flag = 0, ie = 1, no further bits are sent.
- PCF issued in the exact cycle the stop bit completes → flag = 1 afterwards. A wrong device code (6034) → no effect on tx, flag or skip.
